// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch definitions: opcodes, the NOP word, PC source
// encodings, fetch FSM states and the fetch register bundle.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [31:0] INSN_NOP = 32'h0000_0013;

    localparam logic [1:0] PCS_SEQ  = 2'b00;
    localparam logic [1:0] PCS_BR   = 2'b01;
    localparam logic [1:0] PCS_JALR = 2'b10;
    localparam logic [1:0] PCS_HOLD = 2'b11;

    typedef enum logic {
        FS_IDLE = 1'b0,
        FS_WAIT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        fetch_state_t state;
        logic [31:0]  pc;
        logic [31:0]  pc0;
        logic [31:0]  ir;
        logic [31:0]  addr;
        logic         req;
        logic         err;
    } fetch_regs_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: IR -> sign-extended I/S/B/U/J immediate.
// Ports: ir (instruction word), imm32 (0 for R-type and unknown opcodes).
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0] ir,
    output logic [31:0] imm32
);

    logic [6:0] op;
    assign op = ir[6:0];

    always_comb begin
        imm32 = '0;
        unique case (1'b1)
            (op == OP_I) || (op == OP_LOAD) || (op == OP_JALR):
                imm32 = {{20{ir[31]}}, ir[31:20]};
            (op == OP_STORE):
                imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            (op == OP_BRANCH):
                imm32 = {{19{ir[31]}}, ir[31], ir[7],
                         ir[30:25], ir[11:8], 1'b0};
            (op == OP_LUI):
                imm32 = {ir[31:12], 12'b0};
            (op == OP_JAL):
                imm32 = {{11{ir[31]}}, ir[31], ir[19:12],
                         ir[20], ir[30:21], 1'b0};
            (op == OP_R):
                imm32 = '0;
            default:
                imm32 = '0;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns PC/PC0/IR, fetches over imem req/valid, decodes IR.
// Ports: CU strobes (IR_Write, PC_Write, PC0_Write, PC_s, alu_f),
// imem_* handshake, fetch_busy, PC/PC0, decoded fields, imm32, fetch_err.
// Option: FETCH_WATCHDOG_EN adds a WAIT timeout that sets sticky fetch_err.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned WDOG_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        IR_Write,
    input  logic        PC_Write,
    input  logic        PC0_Write,
    input  logic [1:0]  PC_s,
    input  logic [31:0] alu_f,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic        fetch_busy,
    output logic [31:0] PC,
    output logic [31:0] PC0,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] imm32,
    output logic        fetch_err
);

    fetch_regs_t q, d;
    logic [31:0] pc_seq, pc_tgt;
    logic        wdog_hit;

    // PC0 is captured on every fetch commit, so the strobe adds nothing.
    logic unused_pc0_write;
    assign unused_pc0_write = PC0_Write;

    imm_gen u_imm (
        .ir    (q.ir),
        .imm32 (imm32)
    );

    assign pc_seq = q.pc + 32'd4;

    always_comb begin
        pc_tgt = q.pc;
        unique case (1'b1)
            (PC_s == PCS_SEQ):  pc_tgt = pc_seq;
            (PC_s == PCS_BR):   pc_tgt = q.pc0 + imm32;
            (PC_s == PCS_JALR): pc_tgt = alu_f & ~32'd1;
            (PC_s == PCS_HOLD): pc_tgt = q.pc;
            default:            pc_tgt = q.pc;
        endcase
    end

`ifdef FETCH_WATCHDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_q, wdog_d;

    assign wdog_hit = (q.state == FS_WAIT) && !imem_valid
                      && (wdog_q == WDOG_LAST);

    always_comb begin
        wdog_d = wdog_q;
        if (q.state == FS_IDLE) begin
            if (IR_Write)
                wdog_d = '0;
        end else if (!imem_valid) begin
            wdog_d = wdog_q + WDOG_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            wdog_q <= '0;
        else
            wdog_q <= wdog_d;
    end
`else
    assign wdog_hit = 1'b0;

    logic unused_wdog_cfg;
    assign unused_wdog_cfg = (WDOG_CYCLES != 0);
`endif

    always_comb begin
        d = q;
        unique case (q.state)
            FS_IDLE: begin
                if (IR_Write) begin
                    d.addr  = q.pc;
                    d.req   = 1'b1;
                    d.state = FS_WAIT;
                end else if (PC_Write) begin
                    d.pc = pc_tgt;
                end
            end
            FS_WAIT: begin
                if (imem_valid) begin
                    d.ir    = imem_rdata;
                    d.pc0   = q.pc;
                    d.pc    = pc_seq;
                    d.req   = 1'b0;
                    d.state = FS_IDLE;
                end else if (wdog_hit) begin
                    // Give up on the fetch: retire a NOP and move on.
                    d.ir    = INSN_NOP;
                    d.pc0   = q.pc;
                    d.pc    = pc_seq;
                    d.req   = 1'b0;
                    d.err   = 1'b1;
                    d.state = FS_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            q <= '{state: FS_IDLE, pc: RESET_PC, pc0: '0,
                   ir: INSN_NOP, addr: '0, req: 1'b0, err: 1'b0};
        else
            q <= d;
    end

    assign imem_req   = q.req;
    assign imem_addr  = q.addr;
    assign fetch_busy = (q.state == FS_WAIT);
    assign fetch_err  = q.err;
    assign PC         = q.pc;
    assign PC0        = q.pc0;
    assign opcode     = q.ir[6:0];
    assign funct3     = q.ir[14:12];
    assign funct7     = q.ir[31:25];
    assign rs1        = q.ir[19:15];
    assign rs2        = q.ir[24:20];
    assign rd         = q.ir[11:7];

endmodule
